// File: rtl/ps2_receiver.sv
// PS/2 receive-only front end: synchronizes and deglitches the PS/2 clock,
// then deframes 11-bit frames into scan-code bytes with hit/err strobes.
module ps2_receiver #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_hit,
  output logic       ps2_err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clkMeta_q, clkSync_q, datMeta_q, datSync_q;
  logic          filtClk_q, filtClk_d;
  logic [FW-1:0] filtCnt_q, filtCnt_d;
  logic          sampleEvt;
  logic          frameOk;

  state_t        state_q;
  logic [2:0]    bitCnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] toCnt_q;
  logic [7:0]    data_q;
  logic          hit_q, err_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      clkMeta_q <= 1'b1;
      clkSync_q <= 1'b1;
      datMeta_q <= 1'b1;
      datSync_q <= 1'b1;
      filtClk_q <= 1'b1;
      filtCnt_q <= '0;
    end else begin
      clkMeta_q <= ps2_clk;
      clkSync_q <= clkMeta_q;
      datMeta_q <= ps2_dat;
      datSync_q <= datMeta_q;
      filtClk_q <= filtClk_d;
      filtCnt_q <= filtCnt_d;
    end
  end

  // The filtered level flips on the FILTER-th consecutive differing sample;
  // the sample event is that flip when it goes from high to low.
  always_comb begin
    filtClk_d = filtClk_q;
    filtCnt_d = '0;
    sampleEvt = 1'b0;
    if (clkSync_q != filtClk_q) begin
      if (filtCnt_q == FW'(FILTER - 1)) begin
        filtClk_d = clkSync_q;
        sampleEvt = filtClk_q;
      end else begin
        filtCnt_d = filtCnt_q + FW'(1);
      end
    end
  end

  assign frameOk = (^{shift_q, parity_q}) & datSync_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      bitCnt_q <= 3'd0;
      shift_q  <= 8'h00;
      parity_q <= 1'b0;
      toCnt_q  <= '0;
      data_q   <= 8'h00;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      err_q <= 1'b0;
      if (state_q == IDLE || sampleEvt) begin
        toCnt_q <= '0;
      end else begin
        toCnt_q <= toCnt_q + TW'(1);
      end

      // A stalled partial frame is dropped silently.
      if (!sampleEvt && state_q != IDLE && toCnt_q == TW'(TIMEOUT)) begin
        state_q <= IDLE;
        toCnt_q <= '0;
      end else if (sampleEvt) begin
        case (state_q)
          IDLE: begin
            if (!datSync_q) begin
              state_q  <= DATA;
              bitCnt_q <= 3'd0;
            end
          end
          DATA: begin
            shift_q  <= {datSync_q, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            parity_q <= datSync_q;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (frameOk) begin
              data_q <= shift_q;
              hit_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ps2_data = data_q;
  assign ps2_hit  = hit_q;
  assign ps2_err  = err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: frames are driven bit by bit, the
// expected hit/err events are queued and checked as the DUT strobes them.
module tb_ps2_receiver;

  // PS/2 bit time is scaled down relative to the system clock so the whole
  // run stays short; TIMEOUT is scaled to keep the same ratio to a bit time.
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 400;
  localparam int HALF    = 160;

  typedef struct packed {
    logic       isHit;
    logic [7:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Dat = 1'b1;
  logic [7:0] ps2Data;
  logic       ps2Hit;
  logic       ps2Err;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         lastFallCyc = 0;
  logic [7:0] modelData = 8'h00;
  exp_t       expQ[$];
  exp_t       monE;
  logic       prevHit = 1'b0;
  int         delta;

  ps2_receiver #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .ps2_clk (ps2Clk),
    .ps2_dat (ps2Dat),
    .ps2_data(ps2Data),
    .ps2_hit (ps2Hit),
    .ps2_err (ps2Err)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc++;

  // Scoreboard: every strobe must match the next queued expectation.
  always @(negedge clock) begin
    if (ps2Hit && ps2Err) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL hit_err_overlap hit=%0b err=%0b required not both", ps2Hit, ps2Err);
    end
    if (prevHit && ps2Hit) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL hit_width hit high two cycles, required one");
    end
    if (ps2Hit || ps2Err) begin
      vectors++;
      delta = cyc - lastFallCyc;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_strobe hit=%0b err=%0b data=%02h, required no strobe",
                 ps2Hit, ps2Err, ps2Data);
      end else begin
        monE = expQ.pop_front();
        if (ps2Hit !== monE.isHit || ps2Data !== monE.data) begin
          miscompares++;
          $display("[TB] FAIL frame_result hit=%0b data=%02h, required hit=%0b data=%02h",
                   ps2Hit, ps2Data, monE.isHit, monE.data);
        end
        if (delta < FILTER + 1 || delta > FILTER + 3) begin
          miscompares++;
          $display("[TB] FAIL strobe_latency %0d cycles after stop edge, required %0d..%0d",
                   delta, FILTER + 1, FILTER + 3);
        end
      end
    end
    prevHit <= ps2Hit;
  end

  task automatic sendBit(input logic b, input bit glitch);
    @(negedge clock);
    ps2Dat = b;
    repeat (HALF / 2) @(negedge clock);
    if (glitch) begin
      ps2Clk = 1'b0;
      repeat (3) @(negedge clock);
      ps2Clk = 1'b1;
      repeat (20) @(negedge clock);
    end
    ps2Clk = 1'b0;
    lastFallCyc = cyc;
    repeat (HALF) @(negedge clock);
    ps2Clk = 1'b1;
    repeat (HALF / 2) @(negedge clock);
  endtask

  task automatic sendFrame(input logic [7:0] d, input bit badParity, input int glitchBit,
                           input int nBits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ badParity, d, 1'b0};
    if (nBits == 11) begin
      if (!badParity) begin
        modelData = d;
        expQ.push_back({1'b1, d});
      end else begin
        expQ.push_back({1'b0, modelData});
      end
    end
    for (int i = 0; i < nBits; i++) sendBit(f[i], i == glitchBit);
    ps2Dat = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    modelData = 8'h00;
    repeat (5) @(negedge clock);
    vectors++;
    if (ps2Data !== 8'h00 || ps2Hit !== 1'b0 || ps2Err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs data=%02h hit=%0b err=%0b, required 00/0/0",
               ps2Data, ps2Hit, ps2Err);
    end
    resetn = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic test_valid_frame();
    sendFrame(8'h1C, 1'b0, -1, 11);
    vectors++;
    if (expQ.size() != 0 || ps2Data !== 8'h1C) begin
      miscompares++;
      $display("[TB] FAIL valid_frame pending=%0d data=%02h, required 0/1c", expQ.size(), ps2Data);
    end
  endtask

  task automatic test_parity_error();
    sendFrame(8'h1C, 1'b1, -1, 11);
    vectors++;
    if (expQ.size() != 0 || ps2Data !== 8'h1C) begin
      miscompares++;
      $display("[TB] FAIL parity_error pending=%0d data=%02h, required 0/1c", expQ.size(), ps2Data);
    end
  endtask

  task automatic test_back_to_back();
    sendFrame(8'hF0, 1'b0, -1, 11);
    sendFrame(8'h1C, 1'b0, -1, 11);
    vectors++;
    if (expQ.size() != 0 || ps2Data !== 8'h1C) begin
      miscompares++;
      $display("[TB] FAIL back_to_back pending=%0d data=%02h, required 0/1c", expQ.size(), ps2Data);
    end
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 4; g++) begin
      ps2Clk = 1'b0;
      repeat (3) @(negedge clock);
      ps2Clk = 1'b1;
      repeat (25) @(negedge clock);
    end
    repeat (50) @(negedge clock);
    sendFrame(8'h76, 1'b0, 4, 11);
    vectors++;
    if (expQ.size() != 0 || ps2Data !== 8'h76) begin
      miscompares++;
      $display("[TB] FAIL glitch_frame pending=%0d data=%02h, required 0/76", expQ.size(), ps2Data);
    end
  endtask

  task automatic test_timeout();
    sendFrame(8'hFF, 1'b0, -1, 5);
    repeat (TIMEOUT + 100) @(negedge clock);
    vectors++;
    if (ps2Data !== 8'h76) begin
      miscompares++;
      $display("[TB] FAIL timeout_hold data=%02h, required 76", ps2Data);
    end
    sendFrame(8'h5A, 1'b0, -1, 11);
    vectors++;
    if (expQ.size() != 0 || ps2Data !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL timeout_recover pending=%0d data=%02h, required 0/5a", expQ.size(), ps2Data);
    end
  endtask

  task automatic test_reset_midframe();
    sendFrame(8'h33, 1'b0, -1, 5);
    @(negedge clock);
    resetn = 1'b0;
    modelData = 8'h00;
    @(negedge clock);
    resetn = 1'b1;
    vectors++;
    if (ps2Data !== 8'h00 || ps2Hit !== 1'b0 || ps2Err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midframe_reset data=%02h hit=%0b err=%0b, required 00/0/0",
               ps2Data, ps2Hit, ps2Err);
    end
    repeat (50) @(negedge clock);
    sendFrame(8'h45, 1'b0, -1, 11);
    vectors++;
    if (expQ.size() != 0 || ps2Data !== 8'h45) begin
      miscompares++;
      $display("[TB] FAIL reset_recover pending=%0d data=%02h, required 0/45", expQ.size(), ps2Data);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_parity_error();
    test_back_to_back();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    repeat (20) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1600000;
    $display("[TB] FAIL watchdog simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FILTER, default 8; the number of consecutive identical synchronized ps2_clk samples required to accept a level change.
REQ-002 SHALL have parameter TIMEOUT, default 5000; the number of clock cycles without an accepted falling edge after which a partial frame is aborted.
REQ-003 SHALL have port clock, input, 1 bit; the single system clock (50 MHz). All logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit; reset, synchronous and active-low.
REQ-005 SHALL have port ps2_clk, input, 1 bit; raw PS/2 clock line, asynchronous to clock.
REQ-006 SHALL have port ps2_dat, input, 1 bit; raw PS/2 data line, asynchronous to clock.
REQ-007 SHALL have port ps2_data, output, 8 bits; the last correctly received scan-code byte.
REQ-008 SHALL have port ps2_hit, output, 1 bit; a one-cycle strobe when ps2_data is updated.
REQ-009 SHALL have port ps2_err, output, 1 bit; a one-cycle strobe on a parity or stop-bit error.

Function
REQ-010 SHALL pass ps2_clk and ps2_dat each through a 2-flop synchronizer before any use.
REQ-011 SHALL hold a filtered clock level, reset value 1, that changes only after FILTER consecutive equal synchronized samples differ from it; shorter pulses SHALL be ignored.
REQ-012 SHALL generate a sample event in the cycle the filtered clock changes 1->0, sampling the synchronized ps2_dat in that cycle.
REQ-013 SHALL implement states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE: on a sample event with data=0 (start bit), SHALL go to DATA with bit count 0; with data=1, SHALL stay in IDLE with no output.
REQ-015 DATA: SHALL shift in 8 bits LSB first; after the 8th sample event, SHALL go to PARITY; the bit counter SHALL be 3 bits.
REQ-016 PARITY: SHALL capture the parity bit and go to STOP.
REQ-017 STOP: on a sample event, SHALL go to IDLE.
REQ-018 The frame SHALL be valid only if data byte plus parity bit has odd population count and the stop bit is 1.
REQ-019 A valid frame SHALL load ps2_data and pulse ps2_hit high for exactly one cycle, the cycle after the stop-bit sample event.
REQ-020 An invalid frame SHALL pulse ps2_err for one cycle at the same timing, leave ps2_data unchanged, and keep ps2_hit low.
REQ-021 ps2_hit and ps2_err SHALL never be high in the same cycle.
REQ-022 A timeout counter SHALL clear on every sample event and increment each cycle while the state is not IDLE.
REQ-023 When the timeout counter reaches TIMEOUT, the block SHALL return to IDLE, discard the partial frame, and produce no hit and no err.
REQ-024 The counter width SHALL hold TIMEOUT without wrap-around.
REQ-025 ps2_data SHALL hold its value between frames. Back-to-back frames (for example F0 followed by a make code) SHALL each produce their own hit.
REQ-026 The block SHALL be receive-only; it SHALL never drive the PS/2 lines.

Reset
REQ-027 While resetn=0 at a clock edge, the block SHALL set state=IDLE, ps2_data=0x00, ps2_hit=0, ps2_err=0, filtered clock=1, and clear the bit, filter and timeout counters.
REQ-028 A reset asserted mid-frame SHALL abort the frame with no hit and no err. Reception SHALL restart at the next start bit after resetn=1.

Verification
REQ-029 Bench SHALL send frame start 0, data 0x1C, parity 0, stop 1 at 12.5 kHz -> ps2_data=0x1C, ps2_hit exactly 1 cycle, ps2_err=0.
REQ-030 Bench SHALL send the same frame with parity 1 -> ps2_err one-cycle pulse, ps2_hit=0, ps2_data remains at its previous value.
REQ-031 Bench SHALL send 0xF0 then 0x1C back-to-back -> two ps2_hit pulses with ps2_data 0xF0 then 0x1C.
REQ-032 Bench SHALL inject 3-cycle low glitches on ps2_clk while idle and mid-frame (FILTER=8) -> no extra bits sampled, and frame 0x76 is decoded correctly.
REQ-033 Bench SHALL send 4 data bits then hold both lines high -> return to IDLE after TIMEOUT cycles with no hit and no err; a following frame 0x5A yields ps2_data=0x5A.
REQ-034 Bench SHALL pulse resetn low for 1 cycle after 5 bits -> all outputs 0; the next full frame 0x45 yields exactly one hit with ps2_data=0x45.
